// File: rtl/id_stat_pkg.sv
// id_stat_pkg: shared definitions for the identifier statistics block.
//   state_e   - window controller state encoding
//   CNT_W_DEF - default width of every counter and report field
package id_stat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/id_stat_if.sv
// id_stat_if: report channel of id_stat (valid/ready handshake plus fields).
//   rpt_valid  - report fields valid, held until accepted
//   rpt_ready  - consumer accepts when high together with rpt_valid
//   rpt_chars  - cycles counted inside the window
//   rpt_ids    - distinct identifiers (rising edges of id_hit)
//   rpt_hits   - cycles with id_hit=1
//   rpt_maxrun - longest run of consecutive hit cycles
//   rpt_last   - last character sampled with a hit, 0 if none
// master: report producer (id_stat); slave: report consumer.
interface id_stat_if
  import id_stat_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_chars;
  logic [CNT_W-1:0] rpt_ids;
  logic [CNT_W-1:0] rpt_hits;
  logic [CNT_W-1:0] rpt_maxrun;
  logic [7:0]       rpt_last;

  modport master (
    output rpt_valid, rpt_chars, rpt_ids, rpt_hits, rpt_maxrun, rpt_last,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid, rpt_chars, rpt_ids, rpt_hits, rpt_maxrun, rpt_last,
    output rpt_ready
  );

endinterface

// File: rtl/sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear.
//   clk, reset_n - clock, asynchronous active-low reset
//   clr_i        - clear to zero (wins over inc_i)
//   inc_i        - increment by one, holding at all-ones
//   nxt_o        - value the counter takes at the next clock edge
// The next-state value is exported so the owner can capture a result that
// already includes the current cycle's contribution.
module sat_cnt
  import id_stat_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] nxt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nxt_o = cnt_d;

endmodule

// File: rtl/id_stat.sv
// id_stat: gathers statistics on identifier hits over a start/stop window
// and hands them out as a single valid/ready report.
//   clk, reset_n - clock, asynchronous active-low reset
//   char         - character presented alongside id_hit
//   id_hit       - identifier detector output, sampled each edge
//   start, stop  - window open / close pulses
//   busy         - registered, high while in RUN or HOLD
//   rpt          - report channel (master side)
module id_stat
  import id_stat_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] char,
  input  logic       id_hit,
  input  logic       start,
  input  logic       stop,
  output logic       busy,
  id_stat_if.master  rpt
);

  state_e state_q, state_d;

  logic             run_cyc, start_ok, stop_ok, accept;
  logic             hit_cyc;
  logic [CNT_W-1:0] chars_nxt, ids_nxt, hits_nxt, run_nxt;
  logic [CNT_W-1:0] maxrun_q, maxrun_d;
  logic [7:0]       last_q, last_d;
  logic             prev_q, prev_d;
  logic             busy_q;
  logic             rpt_valid_q;
  logic [CNT_W-1:0] rpt_chars_q, rpt_ids_q, rpt_hits_q, rpt_maxrun_q;
  logic [7:0]       rpt_last_q;

  assign run_cyc  = (state_q == RUN);
  assign start_ok = (state_q == IDLE) && start;
  assign stop_ok  = run_cyc && stop;
  assign accept   = (state_q == HOLD) && rpt_valid_q && rpt.rpt_ready;
  assign hit_cyc  = run_cyc && id_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (stop)   state_d = HOLD;
      HOLD:    if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters are cleared on the start cycle so the first RUN cycle counts
  // from zero; the run counter also clears on every non-hit RUN cycle.
  sat_cnt #(.CNT_W(CNT_W)) u_chars (
    .clk(clk), .reset_n(reset_n), .clr_i(start_ok), .inc_i(run_cyc),
    .nxt_o(chars_nxt)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_ids (
    .clk(clk), .reset_n(reset_n), .clr_i(start_ok), .inc_i(hit_cyc && !prev_q),
    .nxt_o(ids_nxt)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_hits (
    .clk(clk), .reset_n(reset_n), .clr_i(start_ok), .inc_i(hit_cyc),
    .nxt_o(hits_nxt)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_run (
    .clk(clk), .reset_n(reset_n), .clr_i(start_ok || (run_cyc && !id_hit)),
    .inc_i(hit_cyc), .nxt_o(run_nxt)
  );

  // Comparing against the post-increment run keeps a run that is still
  // open on the stop cycle in the result.
  always_comb begin
    maxrun_d = maxrun_q;
    last_d   = last_q;
    prev_d   = prev_q;
    if (start_ok) begin
      maxrun_d = '0;
      last_d   = '0;
      prev_d   = 1'b0;
    end else if (run_cyc) begin
      prev_d = id_hit;
      if (id_hit) begin
        last_d = char;
        if (run_nxt > maxrun_q) maxrun_d = run_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      maxrun_q     <= '0;
      last_q       <= '0;
      prev_q       <= 1'b0;
      busy_q       <= 1'b0;
      rpt_valid_q  <= 1'b0;
      rpt_chars_q  <= '0;
      rpt_ids_q    <= '0;
      rpt_hits_q   <= '0;
      rpt_maxrun_q <= '0;
      rpt_last_q   <= '0;
    end else begin
      maxrun_q <= maxrun_d;
      last_q   <= last_d;
      prev_q   <= prev_d;
      busy_q   <= (state_d != IDLE);
      if (stop_ok) begin
        rpt_valid_q  <= 1'b1;
        rpt_chars_q  <= chars_nxt;
        rpt_ids_q    <= ids_nxt;
        rpt_hits_q   <= hits_nxt;
        rpt_maxrun_q <= maxrun_d;
        rpt_last_q   <= last_d;
      end else if (accept) begin
        rpt_valid_q <= 1'b0;
      end
    end
  end

  assign busy           = busy_q;
  assign rpt.rpt_valid  = rpt_valid_q;
  assign rpt.rpt_chars  = rpt_chars_q;
  assign rpt.rpt_ids    = rpt_ids_q;
  assign rpt.rpt_hits   = rpt_hits_q;
  assign rpt.rpt_maxrun = rpt_maxrun_q;
  assign rpt.rpt_last   = rpt_last_q;

endmodule

// File: tb/tb_id_stat.sv
// tb_id_stat: directed bench for id_stat. Two instances share char/id_hit/stop
// and reset: u16 (CNT_W=16) for the general scenarios, u4 (CNT_W=4) for
// saturation. Each has its own start and rpt_ready.
module tb_id_stat;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ch;
  logic       hit, stop, start16, start4;
  logic       busy16, busy4;
  int         checks = 0;
  int         errors = 0;

  id_stat_if #(.CNT_W(16)) r16 ();
  id_stat_if #(.CNT_W(4))  r4 ();

  id_stat #(.CNT_W(16)) u16 (
    .clk(clk), .reset_n(reset_n), .char(ch), .id_hit(hit),
    .start(start16), .stop(stop), .busy(busy16), .rpt(r16)
  );

  id_stat #(.CNT_W(4)) u4 (
    .clk(clk), .reset_n(reset_n), .char(ch), .id_hit(hit),
    .start(start4), .stop(stop), .busy(busy4), .rpt(r4)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; ch = '0; hit = 0; stop = 0; start16 = 0; start4 = 0;
    r16.rpt_ready = 0; r4.rpt_ready = 0;
    #3 reset_n = 1'b0;
    #1;
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy16); end
    checks++; if (r16.rpt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", r16.rpt_valid); end
    checks++; if (r16.rpt_chars !== 16'd0) begin errors++; $display("FAIL rst_chars got %0d want 0", r16.rpt_chars); end
    checks++; if (r16.rpt_ids !== 16'd0) begin errors++; $display("FAIL rst_ids got %0d want 0", r16.rpt_ids); end
    checks++; if (r16.rpt_hits !== 16'd0) begin errors++; $display("FAIL rst_hits got %0d want 0", r16.rpt_hits); end
    checks++; if (r16.rpt_maxrun !== 16'd0) begin errors++; $display("FAIL rst_maxrun got %0d want 0", r16.rpt_maxrun); end
    checks++; if (r16.rpt_last !== 8'd0) begin errors++; $display("FAIL rst_last got %0d want 0", r16.rpt_last); end
    checks++; if (busy4 !== 1'b0 || r4.rpt_valid !== 1'b0) begin errors++; $display("FAIL rst_u4 busy %0b valid %0b want 0 0", busy4, r4.rpt_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    string s = "a12/b3";
    logic  hv [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    start16 = 1; cyc(); start16 = 0;
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", busy16); end
    for (int i = 0; i < 6; i++) begin
      ch = s[i]; hit = hv[i]; stop = (i == 5);
      if (i == 5) begin
        checks++; if (r16.rpt_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b want 0", r16.rpt_valid); end
      end
      cyc();
    end
    stop = 0; hit = 0;
    checks++; if (r16.rpt_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", r16.rpt_valid); end
    checks++; if (r16.rpt_chars !== 16'd6) begin errors++; $display("FAIL basic_chars got %0d want 6", r16.rpt_chars); end
    checks++; if (r16.rpt_ids !== 16'd2) begin errors++; $display("FAIL basic_ids got %0d want 2", r16.rpt_ids); end
    checks++; if (r16.rpt_hits !== 16'd4) begin errors++; $display("FAIL basic_hits got %0d want 4", r16.rpt_hits); end
    checks++; if (r16.rpt_maxrun !== 16'd2) begin errors++; $display("FAIL basic_maxrun got %0d want 2", r16.rpt_maxrun); end
    checks++; if (r16.rpt_last !== 8'h33) begin errors++; $display("FAIL basic_last got %0h want 33", r16.rpt_last); end
  endtask

  task automatic test_hold();
    r16.rpt_ready = 0;
    for (int k = 0; k < 5; k++) begin
      ch = 8'($urandom); hit = k[0]; start16 = 1; stop = 1;
      cyc();
      checks++; if (r16.rpt_valid !== 1'b1 || busy16 !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] valid %0b busy %0b want 1 1", k, r16.rpt_valid, busy16); end
      checks++;
      if (r16.rpt_chars !== 16'd6 || r16.rpt_ids !== 16'd2 || r16.rpt_hits !== 16'd4 ||
          r16.rpt_maxrun !== 16'd2 || r16.rpt_last !== 8'h33) begin
        errors++;
        $display("FAIL hold_stable[%0d] got %0d/%0d/%0d/%0d/%0h want 6/2/4/2/33", k,
                 r16.rpt_chars, r16.rpt_ids, r16.rpt_hits, r16.rpt_maxrun, r16.rpt_last);
      end
    end
    start16 = 0; stop = 0; hit = 0;
    r16.rpt_ready = 1; cyc(); r16.rpt_ready = 0;
    checks++; if (r16.rpt_valid !== 1'b0 || busy16 !== 1'b0) begin errors++; $display("FAIL accept valid %0b busy %0b want 0 0", r16.rpt_valid, busy16); end
    checks++; if (r16.rpt_chars !== 16'd6) begin errors++; $display("FAIL accept_keep chars got %0d want 6", r16.rpt_chars); end
    hit = 1; ch = "q"; cyc(); cyc(); hit = 0;
    checks++; if (r16.rpt_valid !== 1'b0 || busy16 !== 1'b0 || r16.rpt_hits !== 16'd4) begin errors++; $display("FAIL idle_ignore valid %0b busy %0b hits %0d want 0 0 4", r16.rpt_valid, busy16, r16.rpt_hits); end
  endtask

  task automatic test_saturate();
    start4 = 1; cyc(); start4 = 0;
    hit = 1;
    for (int i = 0; i < 20; i++) begin
      ch = 8'(8'h41 + i); stop = (i == 19);
      cyc();
    end
    stop = 0; hit = 0;
    checks++; if (r4.rpt_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %0b want 1", r4.rpt_valid); end
    checks++; if (r4.rpt_chars !== 4'd15) begin errors++; $display("FAIL sat_chars got %0d want 15", r4.rpt_chars); end
    checks++; if (r4.rpt_hits !== 4'd15) begin errors++; $display("FAIL sat_hits got %0d want 15", r4.rpt_hits); end
    checks++; if (r4.rpt_maxrun !== 4'd15) begin errors++; $display("FAIL sat_maxrun got %0d want 15", r4.rpt_maxrun); end
    checks++; if (r4.rpt_ids !== 4'd1) begin errors++; $display("FAIL sat_ids got %0d want 1", r4.rpt_ids); end
    checks++; if (r4.rpt_last !== 8'h54) begin errors++; $display("FAIL sat_last got %0h want 54", r4.rpt_last); end
    checks++; if (r16.rpt_valid !== 1'b0 || busy16 !== 1'b0 || r16.rpt_chars !== 16'd6) begin errors++; $display("FAIL sat_u16_idle valid %0b busy %0b chars %0d want 0 0 6", r16.rpt_valid, busy16, r16.rpt_chars); end
    r4.rpt_ready = 1; cyc(); r4.rpt_ready = 0;
    checks++; if (r4.rpt_valid !== 1'b0) begin errors++; $display("FAIL sat_accept got %0b want 0", r4.rpt_valid); end
  endtask

  task automatic test_reset_mid_run();
    start16 = 1; cyc(); start16 = 0;
    hit = 1; ch = "z";
    repeat (3) cyc();
    hit = 0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy16 !== 1'b0 || r16.rpt_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctl busy %0b valid %0b want 0 0", busy16, r16.rpt_valid); end
    checks++; if (r16.rpt_chars !== 16'd0 || r16.rpt_last !== 8'd0 || r16.rpt_hits !== 16'd0) begin errors++; $display("FAIL midrst_u16 chars %0d last %0h hits %0d want 0 0 0", r16.rpt_chars, r16.rpt_last, r16.rpt_hits); end
    checks++; if (r4.rpt_chars !== 4'd0 || r4.rpt_maxrun !== 4'd0) begin errors++; $display("FAIL midrst_u4 chars %0d maxrun %0d want 0 0", r4.rpt_chars, r4.rpt_maxrun); end
    @(negedge clk) reset_n = 1'b1;
    stop = 1; cyc(); stop = 0;
    cyc(); cyc();
    checks++; if (r16.rpt_valid !== 1'b0 || busy16 !== 1'b0) begin errors++; $display("FAIL midrst_norpt valid %0b busy %0b want 0 0", r16.rpt_valid, busy16); end
  endtask

  task automatic test_start_stop();
    #2 reset_n = 1'b0;
    start16 = 1; stop = 1; hit = 0;
    @(negedge clk) reset_n = 1'b1;
    cyc();
    start16 = 0; stop = 0;
    checks++; if (busy16 !== 1'b1 || r16.rpt_valid !== 1'b0) begin errors++; $display("FAIL ss_enter busy %0b valid %0b want 1 0", busy16, r16.rpt_valid); end
    cyc(); cyc();
    checks++; if (r16.rpt_valid !== 1'b0) begin errors++; $display("FAIL ss_norpt got %0b want 0", r16.rpt_valid); end
    stop = 1; cyc(); stop = 0;
    checks++; if (r16.rpt_valid !== 1'b1) begin errors++; $display("FAIL ss_valid got %0b want 1", r16.rpt_valid); end
    checks++; if (r16.rpt_chars !== 16'd3) begin errors++; $display("FAIL ss_chars got %0d want 3", r16.rpt_chars); end
    checks++; if (r16.rpt_ids !== 16'd0 || r16.rpt_hits !== 16'd0 || r16.rpt_maxrun !== 16'd0) begin errors++; $display("FAIL ss_zero ids %0d hits %0d maxrun %0d want 0 0 0", r16.rpt_ids, r16.rpt_hits, r16.rpt_maxrun); end
    checks++; if (r16.rpt_last !== 8'd0) begin errors++; $display("FAIL ss_last got %0h want 0", r16.rpt_last); end
    r16.rpt_ready = 1; cyc(); r16.rpt_ready = 0;
  endtask

  task automatic test_first_hit();
    stop = 1; cyc(); stop = 0;
    checks++; if (busy16 !== 1'b0 || r16.rpt_valid !== 1'b0) begin errors++; $display("FAIL idle_stop busy %0b valid %0b want 0 0", busy16, r16.rpt_valid); end
    start16 = 1; cyc(); start16 = 0;
    hit = 1; ch = "x"; cyc();
    hit = 0; ch = "y"; stop = 1; cyc(); stop = 0;
    checks++; if (r16.rpt_ids !== 16'd1) begin errors++; $display("FAIL first_ids got %0d want 1", r16.rpt_ids); end
    checks++; if (r16.rpt_chars !== 16'd2 || r16.rpt_hits !== 16'd1 || r16.rpt_maxrun !== 16'd1) begin errors++; $display("FAIL first_cnt chars %0d hits %0d maxrun %0d want 2 1 1", r16.rpt_chars, r16.rpt_hits, r16.rpt_maxrun); end
    checks++; if (r16.rpt_last !== 8'h78) begin errors++; $display("FAIL first_last got %0h want 78", r16.rpt_last); end
  endtask

  task automatic test_back_to_back();
    string s = "pqr";
    r16.rpt_ready = 1; cyc(); r16.rpt_ready = 0;
    start16 = 1; cyc(); start16 = 0;
    hit = 1;
    for (int i = 0; i < 3; i++) begin
      ch = s[i]; stop = (i == 2);
      cyc();
    end
    stop = 0; hit = 0;
    checks++; if (r16.rpt_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b want 1", r16.rpt_valid); end
    checks++; if (r16.rpt_maxrun !== 16'd3 || r16.rpt_ids !== 16'd1 || r16.rpt_hits !== 16'd3 || r16.rpt_chars !== 16'd3) begin errors++; $display("FAIL b2b_cnt maxrun %0d ids %0d hits %0d chars %0d want 3 1 3 3", r16.rpt_maxrun, r16.rpt_ids, r16.rpt_hits, r16.rpt_chars); end
    checks++; if (r16.rpt_last !== 8'h72) begin errors++; $display("FAIL b2b_last got %0h want 72", r16.rpt_last); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_saturate();
    test_reset_mid_run();
    test_start_stop();
    test_first_hit();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
